// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, shared-memory read handshake and IF/ID register.
// Optional branch delay slot is enabled by defining FETCH_DELAY_SLOT_EN.
module fetch_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        ifi_stall,
    input  logic        ifi_branch,
    input  logic [15:0] ifi_new_pc,
    input  logic        ifi_flush,
    input  logic [15:0] ifi_flush_pc,
    input  logic        ifi_mem_busy,
    output logic        ifo_mem_req,
    output logic [15:0] ifo_mem_addr,
    input  logic        ifi_mem_ack,
    input  logic [15:0] ifi_mem_data,
    output logic [15:0] ifo_addr,
    output logic [15:0] ifo_instr,
    output logic        ifo_valid
);

    localparam logic [15:0] RESET_PC  = 16'h0000;
    localparam logic [15:0] NOP_INSTR = 16'h0800;

    typedef enum logic {StFetch, StDslot} state_e;

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] target_q, target_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic        complete;

    assign ifo_mem_req  = rst & ~ifi_stall & ~ifi_flush & ~ifi_mem_busy;
    assign ifo_mem_addr = pc_q;
    assign complete     = ifo_mem_req & ifi_mem_ack;

    assign ifo_addr  = addr_q;
    assign ifo_instr = instr_q;
    assign ifo_valid = valid_q;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        target_d = target_q;
        addr_d   = addr_q;
        instr_d  = instr_q;
        valid_d  = valid_q;

        if (ifi_flush) begin
            pc_d    = ifi_flush_pc;
            state_d = StFetch;
            addr_d  = pc_q;
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else if (!ifi_stall) begin
            // Default this edge to a bubble; a completed fetch overrides it below.
            addr_d  = pc_q;
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
            unique case (state_q)
                StFetch: begin
                    if (ifi_branch) begin
`ifdef FETCH_DELAY_SLOT_EN
                        if (complete) begin
                            instr_d = ifi_mem_data;
                            valid_d = 1'b1;
                            pc_d    = ifi_new_pc;
                        end else begin
                            target_d = ifi_new_pc;
                            state_d  = StDslot;
                        end
`else
                        pc_d = ifi_new_pc;
`endif
                    end else if (complete) begin
                        instr_d = ifi_mem_data;
                        valid_d = 1'b1;
                        pc_d    = pc_q + 16'd1;
                    end
                end
                StDslot: begin
                    if (complete) begin
                        instr_d = ifi_mem_data;
                        valid_d = 1'b1;
                        pc_d    = target_q;
                        state_d = StFetch;
                    end
                end
                default: state_d = StFetch;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= StFetch;
            pc_q     <= RESET_PC;
            target_q <= 16'h0000;
            addr_q   <= 16'h0000;
            instr_q  <= NOP_INSTR;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            target_q <= target_d;
            addr_q   <= addr_d;
            instr_q  <= instr_d;
            valid_q  <= valid_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, then random traffic against a reference model.
module tb_fetch_stage;

    localparam logic [15:0] NOP = 16'h0800;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifi_stall;
    logic        ifi_branch;
    logic [15:0] ifi_new_pc;
    logic        ifi_flush;
    logic [15:0] ifi_flush_pc;
    logic        ifi_mem_busy;
    logic        ifo_mem_req;
    logic [15:0] ifo_mem_addr;
    logic        ifi_mem_ack;
    logic [15:0] ifi_mem_data;
    logic [15:0] ifo_addr;
    logic [15:0] ifo_instr;
    logic        ifo_valid;

    fetch_stage dut (
        .clk          (clk),
        .rst          (rst),
        .ifi_stall    (ifi_stall),
        .ifi_branch   (ifi_branch),
        .ifi_new_pc   (ifi_new_pc),
        .ifi_flush    (ifi_flush),
        .ifi_flush_pc (ifi_flush_pc),
        .ifi_mem_busy (ifi_mem_busy),
        .ifo_mem_req  (ifo_mem_req),
        .ifo_mem_addr (ifo_mem_addr),
        .ifi_mem_ack  (ifi_mem_ack),
        .ifi_mem_data (ifi_mem_data),
        .ifo_addr     (ifo_addr),
        .ifo_instr    (ifo_instr),
        .ifo_valid    (ifo_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, stall, branch, flush, busy, ack;
        logic [15:0] new_pc, flush_pc;
        logic [15:0] e_addr, e_instr, e_maddr;
        logic        e_valid;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model: program counter, pending delay-slot target, IF/ID contents.
    logic [15:0] m_pc = 16'h0000;
    logic [15:0] m_tgt = 16'h0000;
    bit          m_in_slot = 1'b0;
    logic [15:0] m_addr, m_instr;
    logic        m_valid;
    bit          primed = 1'b0;

    function automatic vec_t mk(input logic r, s, b, input logic [15:0] np, input logic f,
                                input logic [15:0] fp, input logic bz, a,
                                input logic [15:0] ea, ei, input logic ev,
                                input logic [15:0] em);
        vec_t v;
        v.rst = r; v.stall = s; v.branch = b; v.new_pc = np; v.flush = f; v.flush_pc = fp;
        v.busy = bz; v.ack = a; v.e_addr = ea; v.e_instr = ei; v.e_valid = ev; v.e_maddr = em;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_step(input vec_t v);
        logic [15:0] word;
        bit          got;
        word = m_pc ^ 16'hA000;
        got  = !v.busy && v.ack;
        if (!v.rst) begin
            m_pc = 16'h0000; m_tgt = 16'h0000; m_in_slot = 1'b0;
            m_addr = 16'h0000; m_instr = NOP; m_valid = 1'b0; primed = 1'b1;
        end else if (v.flush) begin
            m_addr = m_pc; m_instr = NOP; m_valid = 1'b0;
            m_pc = v.flush_pc; m_in_slot = 1'b0;
        end else if (!v.stall) begin
            m_addr = m_pc;
            m_instr = got ? word : NOP;
            m_valid = got;
            if (m_in_slot) begin
                if (got) begin m_pc = m_tgt; m_in_slot = 1'b0; end
            end else if (v.branch) begin
`ifdef FETCH_DELAY_SLOT_EN
                if (got) m_pc = v.new_pc;
                else begin m_tgt = v.new_pc; m_in_slot = 1'b1; end
`else
                m_instr = NOP; m_valid = 1'b0; m_pc = v.new_pc;
`endif
            end else if (got) begin
                m_pc = m_pc + 16'd1;
            end
        end
    endtask

    task automatic apply(input vec_t v, input bit use_tbl);
        rst = v.rst; ifi_stall = v.stall; ifi_branch = v.branch; ifi_new_pc = v.new_pc;
        ifi_flush = v.flush; ifi_flush_pc = v.flush_pc; ifi_mem_busy = v.busy;
        ifi_mem_ack = v.ack; ifi_mem_data = m_pc ^ 16'hA000;
        #1;
        chk("mem_req", {15'd0, ifo_mem_req},
            {15'd0, v.rst && !v.stall && !v.flush && !v.busy});
        if (primed) chk("mem_addr_pre", ifo_mem_addr, m_pc);
        @(posedge clk);
        model_step(v);
        #1;
        if (use_tbl) begin
            chk("tbl_addr", ifo_addr, v.e_addr);
            chk("tbl_instr", ifo_instr, v.e_instr);
            chk("tbl_valid", {15'd0, ifo_valid}, {15'd0, v.e_valid});
            chk("tbl_mem_addr", ifo_mem_addr, v.e_maddr);
        end else begin
            chk("rnd_addr", ifo_addr, m_addr);
            chk("rnd_instr", ifo_instr, m_instr);
            chk("rnd_valid", {15'd0, ifo_valid}, {15'd0, m_valid});
            chk("rnd_mem_addr", ifo_mem_addr, m_pc);
        end
    endtask

    initial begin
        vec_t v;
        // Reset, then zero-wait streaming from address 0.
        tbl.push_back(mk(0,0,0,16'h0,0,16'h0,0,0, 16'h0000, NOP, 0, 16'h0000));
        tbl.push_back(mk(0,0,0,16'h0,0,16'h0,0,1, 16'h0000, NOP, 0, 16'h0000));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(1,0,0,16'h0,0,16'h0,0,1, 16'(i), 16'(i) ^ 16'hA000, 1,
                             16'(i + 1)));
        // Ack held off two cycles at PC 5.
        tbl.push_back(mk(1,0,0,16'h0,0,16'h0,0,0, 16'h0005, NOP, 0, 16'h0005));
        tbl.push_back(mk(1,0,0,16'h0,0,16'h0,0,0, 16'h0005, NOP, 0, 16'h0005));
        tbl.push_back(mk(1,0,0,16'h0,0,16'h0,0,1, 16'h0005, 16'hA005, 1, 16'h0006));
        for (int i = 6; i <= 10; i++)
            tbl.push_back(mk(1,0,0,16'h0,0,16'h0,0,1, 16'(i), 16'(i) ^ 16'hA000, 1,
                             16'(i + 1)));
        // Branch to 0x40 resolved while PC 11 is fetched with zero wait.
`ifdef FETCH_DELAY_SLOT_EN
        tbl.push_back(mk(1,0,1,16'h40,0,16'h0,0,1, 16'h000B, 16'hA00B, 1, 16'h0040));
`else
        tbl.push_back(mk(1,0,1,16'h40,0,16'h0,0,1, 16'h000B, NOP, 0, 16'h0040));
`endif
        tbl.push_back(mk(1,0,0,16'h0,0,16'h0,0,1, 16'h0040, 16'hA040, 1, 16'h0041));
        // Stall with busy pulses: everything frozen.
        tbl.push_back(mk(1,1,1,16'h77,0,16'h0,0,1, 16'h0040, 16'hA040, 1, 16'h0041));
        tbl.push_back(mk(1,1,0,16'h0,0,16'h0,1,1, 16'h0040, 16'hA040, 1, 16'h0041));
        tbl.push_back(mk(1,1,0,16'h0,0,16'h0,0,0, 16'h0040, 16'hA040, 1, 16'h0041));
        tbl.push_back(mk(1,0,0,16'h0,0,16'h0,1,1, 16'h0041, NOP, 0, 16'h0041));
        // Flush during stall wins; same-cycle ack is dropped.
        tbl.push_back(mk(1,1,0,16'h0,1,16'h8,0,1, 16'h0041, NOP, 0, 16'h0008));
        tbl.push_back(mk(1,0,0,16'h0,0,16'h0,0,1, 16'h0008, 16'hA008, 1, 16'h0009));
        // PC wrap at 0xFFFF.
        tbl.push_back(mk(1,0,0,16'h0,1,16'hFFFF,0,1, 16'h0009, NOP, 0, 16'hFFFF));
        tbl.push_back(mk(1,0,0,16'h0,0,16'h0,0,1, 16'hFFFF, 16'h5FFF, 1, 16'h0000));
        // Reset while a fetch is pending; ack after release serves RESET_PC.
        tbl.push_back(mk(1,0,0,16'h0,1,16'h0123,0,0, 16'h0000, NOP, 0, 16'h0123));
        tbl.push_back(mk(1,0,0,16'h0,0,16'h0,0,0, 16'h0123, NOP, 0, 16'h0123));
        tbl.push_back(mk(0,0,0,16'h0,0,16'h0,0,1, 16'h0000, NOP, 0, 16'h0000));
        tbl.push_back(mk(1,0,0,16'h0,0,16'h0,0,1, 16'h0000, 16'hA000, 1, 16'h0001));
`ifdef FETCH_DELAY_SLOT_EN
        // Branch without completion enters the delay slot; branch in slot ignored.
        tbl.push_back(mk(1,0,1,16'h40,0,16'h0,0,0, 16'h0001, NOP, 0, 16'h0001));
        tbl.push_back(mk(1,0,1,16'h99,0,16'h0,0,1, 16'h0001, 16'hA001, 1, 16'h0040));
        tbl.push_back(mk(1,0,0,16'h0,0,16'h0,0,1, 16'h0040, 16'hA040, 1, 16'h0041));
        // Flush while waiting in the delay slot: slot and target both discarded.
        tbl.push_back(mk(1,0,1,16'h70,0,16'h0,0,0, 16'h0041, NOP, 0, 16'h0041));
        tbl.push_back(mk(1,1,0,16'h0,0,16'h0,0,1, 16'h0041, NOP, 0, 16'h0041));
        tbl.push_back(mk(1,0,0,16'h0,1,16'h8,0,1, 16'h0041, NOP, 0, 16'h0008));
        tbl.push_back(mk(1,0,0,16'h0,0,16'h0,0,1, 16'h0008, 16'hA008, 1, 16'h0009));
        tbl.push_back(mk(1,0,0,16'h0,0,16'h0,0,1, 16'h0009, 16'hA009, 1, 16'h000A));
`else
        // Branch without completion redirects immediately.
        tbl.push_back(mk(1,0,1,16'h40,0,16'h0,0,0, 16'h0001, NOP, 0, 16'h0040));
        tbl.push_back(mk(1,0,0,16'h0,0,16'h0,0,1, 16'h0040, 16'hA040, 1, 16'h0041));
        tbl.push_back(mk(1,0,1,16'h70,0,16'h0,1,1, 16'h0041, NOP, 0, 16'h0070));
        tbl.push_back(mk(1,0,0,16'h0,0,16'h0,0,1, 16'h0070, 16'hA070, 1, 16'h0071));
`endif
        foreach (tbl[i]) apply(tbl[i], 1'b1);

        for (int i = 0; i < 3000; i++) begin
            v.rst      = ($urandom_range(99) >= 2);
            v.stall    = ($urandom_range(99) < 15);
            v.flush    = ($urandom_range(99) < 5);
            v.branch   = ($urandom_range(99) < 15);
            v.busy     = ($urandom_range(99) < 15);
            v.ack      = ($urandom_range(99) < 60);
            v.new_pc   = ($urandom_range(3) == 0) ? 16'hFFFE + 16'($urandom_range(1))
                                                  : 16'($urandom);
            v.flush_pc = 16'($urandom);
            v.e_addr = 16'h0; v.e_instr = 16'h0; v.e_valid = 1'b0; v.e_maddr = 16'h0;
            apply(v, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
